// File: rtl/lram_arbiter_if.sv
// ---------------------------------------------------------------------------
// lram_arbiter_if
// Bundles the two requester ports and the LUTRAM bank port of lram_arbiter.
//
// Parameters:
//   DW - data width (LUTRAM bank width)
//   AW - requester address width
//
// Signals:
//   a_* / b_*  requester A / B: valid, we, addr, wdata (requests) and
//              ready, rvalid, rdata (accept strobe and read response)
//   ram_addr   LUTRAM address to all read/write ports
//   ram_data   LUTRAM write data
//   ram_wen    LUTRAM write enable
//   ram_y      LUTRAM asynchronous read data
//
// Modports:
//   slave  - the arbiter
//   master - the environment: both requesters plus the LUTRAM bank
// ---------------------------------------------------------------------------
interface lram_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          a_valid;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_ready;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_valid;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ready;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wen;
    logic [DW-1:0] ram_y;

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        input  b_valid, b_we, b_addr, b_wdata,
        input  ram_y,
        output a_ready, a_rvalid, a_rdata,
        output b_ready, b_rvalid, b_rdata,
        output ram_addr, ram_data, ram_wen
    );

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        output b_valid, b_we, b_addr, b_wdata,
        output ram_y,
        input  a_ready, a_rvalid, a_rdata,
        input  b_ready, b_rvalid, b_rdata,
        input  ram_addr, ram_data, ram_wen
    );
endinterface

// File: rtl/lram_arbiter.sv
// ---------------------------------------------------------------------------
// lram_arbiter
// Two-requester arbiter in front of a single LUTRAM bank (RAM64M8 style:
// asynchronous read, write on the rising clock edge). One request is
// accepted per cycle; reads return one cycle later on the winner's
// rvalid/rdata, writes commit on the edge that ends the accept cycle.
//
// Parameters:
//   DW - data width, equal to the LUTRAM bank width
//   AW - requester address width (1..6)
//
// Ports:
//   clock - single clock, also the LUTRAM write clock
//   reset - synchronous, active-high
//   bus   - lram_arbiter_if.slave: requester A/B handshakes and LUTRAM port
//
// Configuration macro:
//   LRAM_ARBITER_RR_EN - defined: round-robin on contention (the requester
//                        that did not win last time wins).
//                        undefined: fixed priority, A always wins.
// ---------------------------------------------------------------------------
module lram_arbiter #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic           clock,
    input  logic           reset,
    lram_arbiter_if.slave  bus
);

    localparam logic [0:0] GRANT_A = 1'b0;
    localparam logic [0:0] GRANT_B = 1'b1;

`ifdef LRAM_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic [0:0]    last_grant;
    logic          a_wins_tie;
    logic          grant_a;
    logic          grant_b;
    logic          accept;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    // Last driven bus values, replayed while idle
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    logic          a_rvalid_p1;
    logic          b_rvalid_p1;
    logic [DW-1:0] a_rdata_p1;
    logic [DW-1:0] b_rdata_p1;

    // ---- stage p0: arbitration and LUTRAM drive (combinational) ----
    // last_grant is maintained in both builds; it only steers ties in RR.
    assign a_wins_tie = !RR_EN || (last_grant == GRANT_B);

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (bus.a_valid && bus.b_valid) begin
                grant_a = a_wins_tie;
                grant_b = !a_wins_tie;
            end else begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid;
            end
        end
    end

    assign accept    = grant_a || grant_b;
    assign acc_we    = grant_b ? bus.b_we    : bus.a_we;
    assign acc_addr  = grant_b ? bus.b_addr  : bus.a_addr;
    assign acc_wdata = grant_b ? bus.b_wdata : bus.a_wdata;

    assign bus.a_ready  = grant_a;
    assign bus.b_ready  = grant_b;
    assign bus.ram_wen  = accept && acc_we;
    assign bus.ram_addr = accept ? acc_addr  : addr_q;
    assign bus.ram_data = accept ? acc_wdata : data_q;

    // Responses are masked while reset is high so a read accepted just
    // before reset never shows up as a response.
    assign bus.a_rvalid = a_rvalid_p1 && !reset;
    assign bus.b_rvalid = b_rvalid_p1 && !reset;
    assign bus.a_rdata  = reset ? '0 : a_rdata_p1;
    assign bus.b_rdata  = reset ? '0 : b_rdata_p1;

    // ---- stage p1: read response and arbitration history ----
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant  <= GRANT_B;
            addr_q      <= '0;
            data_q      <= '0;
            a_rvalid_p1 <= 1'b0;
            b_rvalid_p1 <= 1'b0;
            a_rdata_p1  <= '0;
            b_rdata_p1  <= '0;
        end else begin
            a_rvalid_p1 <= grant_a && !bus.a_we;
            b_rvalid_p1 <= grant_b && !bus.b_we;
            if (grant_a && !bus.a_we) begin
                a_rdata_p1 <= bus.ram_y;
            end
            if (grant_b && !bus.b_we) begin
                b_rdata_p1 <= bus.ram_y;
            end
            if (accept) begin
                last_grant <= grant_b ? GRANT_B : GRANT_A;
                addr_q     <= acc_addr;
                data_q     <= acc_wdata;
            end
        end
    end

endmodule
